// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multicycle controller and the datapath/memories.
interface multicycle_controller_if #(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
);
  logic [INSTR_W-1:0] decoded_instr;
  logic               imem_ready;
  logic               dmem_ready;
  logic               md_done;
  logic               imem_r;
  logic               ir_w;
  logic               pc_w;
  logic               dmem_r;
  logic               dmem_w;
  logic               regfile_w;
  logic               md_start;
  logic               illegal;
  logic [2:0]         state;
  logic [CNT_W-1:0]   retired_cnt;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    input  decoded_instr, imem_ready, dmem_ready, md_done,
    output imem_r, ir_w, pc_w, dmem_r, dmem_w, regfile_w, md_start, illegal,
           state, retired_cnt, stall_cnt
  );

  modport slave (
    output decoded_instr, imem_ready, dmem_ready, md_done,
    input  imem_r, ir_w, pc_w, dmem_r, dmem_w, regfile_w, md_start, illegal,
           state, retired_cnt, stall_cnt
  );
endinterface

// File: rtl/multicycle_controller.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the multicycle core, with retire/stall debug counters.
module multicycle_controller #(
  parameter int                 INSTR_W    = 32,
  parameter logic [INSTR_W-1:0] LOAD_MASK  = INSTR_W'(32'h0080_0000),
  parameter logic [INSTR_W-1:0] STORE_MASK = INSTR_W'(32'h0100_0000),
  parameter logic [INSTR_W-1:0] NOWB_MASK  = INSTR_W'(32'h2701_0000),
  parameter logic [INSTR_W-1:0] MD_MASK    = INSTR_W'(32'h8000_0000),
  parameter int                 CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               armed_q, armed_d;
  logic [CNT_W-1:0]   ret_q, ret_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic [INSTR_W-1:0] di;
  logic               ld, st, md, nowb, bad, md_go;
  logic               imem_r_c, ir_w_c, pc_w_c, dmem_r_c, dmem_w_c, rf_w_c, md_start_c, ill_c;

  assign di   = bus.decoded_instr;
  assign ld   = |(di & LOAD_MASK);
  assign st   = |(di & STORE_MASK);
  assign md   = |(di & MD_MASK);
  assign nowb = |(di & NOWB_MASK);
  // x & (x-1) clears the lowest set bit; anything left means more than one bit is set
  assign bad  = (di == '0) || ((di & (di - INSTR_W'(1))) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      armed_q <= 1'b0;
      ret_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      ret_q   <= ret_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    ret_d      = ret_q;
    stall_d    = stall_q;
    imem_r_c   = 1'b0;
    ir_w_c     = 1'b0;
    pc_w_c     = 1'b0;
    dmem_r_c   = 1'b0;
    dmem_w_c   = 1'b0;
    rf_w_c     = 1'b0;
    md_start_c = 1'b0;
    ill_c      = 1'b0;
    md_go      = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_r_c = 1'b1;
        if (bus.imem_ready) begin
          ir_w_c  = 1'b1;
          state_d = S_DECODE;
        end else begin
          stall_d = stall_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        if (bad) begin
          ill_c   = 1'b1;
          pc_w_c  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        md_go = !md || bus.md_done;
        // armed flag limits md_start to the first EXEC cycle of a mul/div op
        if (md && !armed_q) begin
          md_start_c = 1'b1;
          armed_d    = 1'b1;
        end
        if (md_go) begin
          armed_d = 1'b0;
          if (ld || st) begin
            state_d = S_MEM;
          end else if (nowb) begin
            pc_w_c  = 1'b1;
            ret_d   = ret_q + CNT_W'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          stall_d = stall_q + CNT_W'(1);
        end
      end
      S_MEM: begin
        dmem_r_c = ld;
        dmem_w_c = st && !ld;
        if (bus.dmem_ready) begin
          if (ld) begin
            state_d = S_WB;
          end else begin
            pc_w_c  = 1'b1;
            ret_d   = ret_q + CNT_W'(1);
            state_d = S_FETCH;
          end
        end else begin
          stall_d = stall_q + CNT_W'(1);
        end
      end
      S_WB: begin
        rf_w_c  = 1'b1;
        pc_w_c  = 1'b1;
        ret_d   = ret_q + CNT_W'(1);
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
        armed_d = 1'b0;
      end
    endcase
  end

  // Strobes are gated by rst_n so nothing fires while reset is held
  assign bus.imem_r      = imem_r_c   & rst_n;
  assign bus.ir_w        = ir_w_c     & rst_n;
  assign bus.pc_w        = pc_w_c     & rst_n;
  assign bus.dmem_r      = dmem_r_c   & rst_n;
  assign bus.dmem_w      = dmem_w_c   & rst_n;
  assign bus.regfile_w   = rf_w_c     & rst_n;
  assign bus.md_start    = md_start_c & rst_n;
  assign bus.illegal     = ill_c      & rst_n;
  assign bus.state       = state_q;
  assign bus.retired_cnt = ret_q;
  assign bus.stall_cnt   = stall_q;

endmodule
